// File: rtl/adpcm_pkg.sv
// Shared definitions for the ADPCM byte-path blocks.
// - ADPCM_GRAY(b): binary-to-Gray conversion used to build the state codes.
// - HDR_BYTES, IDX_MAX: block header length and largest legal step index.
// - state_t: 3-bit Gray-coded block unpacker states.

`ifndef ADPCM_GRAY
`define ADPCM_GRAY(b) ((b) ^ ((b) >> 1))
`endif

package adpcm_pkg;

    localparam int HDR_BYTES = 4;
    localparam int IDX_MAX   = 88;

    localparam logic [2:0] ST_H0   = `ADPCM_GRAY(3'd0);
    localparam logic [2:0] ST_H1   = `ADPCM_GRAY(3'd1);
    localparam logic [2:0] ST_H2   = `ADPCM_GRAY(3'd2);
    localparam logic [2:0] ST_H3   = `ADPCM_GRAY(3'd3);
    localparam logic [2:0] ST_DATA = `ADPCM_GRAY(3'd4);
    localparam logic [2:0] ST_LO   = `ADPCM_GRAY(3'd5);
    localparam logic [2:0] ST_HI   = `ADPCM_GRAY(3'd6);
    localparam logic [2:0] ST_SKIP = `ADPCM_GRAY(3'd7);

    typedef enum logic [2:0] {
        S_H0   = ST_H0,
        S_H1   = ST_H1,
        S_H2   = ST_H2,
        S_H3   = ST_H3,
        S_DATA = ST_DATA,
        S_LO   = ST_LO,
        S_HI   = ST_HI,
        S_SKIP = ST_SKIP
    } state_t;

endpackage

// File: rtl/adpcm_toggle_detect.sv
// Registered toggle detector: turns a toggle-encoded strobe into a one-cycle
// pulse on the cycle after each edge of the input.
// Ports:
//   i_clk     clock
//   i_sig     toggle input
//   o_toggle  1 while i_sig differs from its registered copy
// The delay register has no reset and no enable so it always follows i_sig;
// that way leaving reset or soft clear never produces a spurious pulse.

module adpcm_toggle_detect (
    input  logic i_clk,
    input  logic i_sig,
    output logic o_toggle
);

    logic r_sig_d;

    always_ff @(posedge i_clk) begin
        r_sig_d <= i_sig;
    end

    assign o_toggle = i_sig ^ r_sig_d;

endmodule

// File: rtl/adpcm_block_unpacker.sv
// IMA-ADPCM mono block reader: parses the 4-byte block header (predictor,
// step index, reserved), then splits each data byte into two nibbles (low
// first) and hands them to the decoder over a toggle-req / level-ack link.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_enable               0 = soft clear (same as reset)
//   i_push, i_rx_byte      toggle strobe + byte from the byte source
//   o_full                 nibbles pending; pushes now are dropped (o_ovf)
//   i_ack                  decoder idle level
//   o_req, o_tx_adpcm      toggle request + nibble to the decoder
//   o_hdr_valid            one-cycle pulse when o_hdr_predict/o_hdr_idx update
//   o_hdr_predict          signed header predictor
//   o_hdr_idx              header step index
//   o_hdr_err              sticky: header index above 88 seen
//   o_ovf                  sticky: push while full
//   o_cst                  current state (debug)
// Build option ADPCM_HDR_CLAMP_EN: out-of-range header index is clamped to 88
// and the block is decoded; otherwise it flags o_hdr_err and the block's data
// bytes are skipped.
//
// state | meaning
// H0    | wait predictor low byte
// H1    | wait predictor high byte
// H2    | wait step index byte
// H3    | wait reserved byte, then commit header
// DATA  | wait data byte; low nibble issued on capture
// LO    | low nibble with decoder; wait ack fall/rise, then issue high nibble
// HI    | high nibble with decoder; wait ack fall/rise, then next byte/block
// SKIP  | discard the data bytes of a block with a bad header

module adpcm_block_unpacker
    import adpcm_pkg::*;
#(
    parameter int unsigned BLOCK_BYTES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_enable,
    input  logic        i_push,
    input  logic [7:0]  i_rx_byte,
    output logic        o_full,
    input  logic        i_ack,
    output logic        o_req,
    output logic [3:0]  o_tx_adpcm,
    output logic        o_hdr_valid,
    output logic [15:0] o_hdr_predict,
    output logic [6:0]  o_hdr_idx,
    output logic        o_hdr_err,
    output logic        o_ovf,
    output logic [2:0]  o_cst
);

    localparam int CNT_W = $clog2(BLOCK_BYTES + 1);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [7:0]         r_pred_lo, r_pred_hi, r_idx_byte;
    logic [3:0]         r_byte_hi;
    logic               r_ack_low, r_req, r_hdr_valid, r_hdr_err, r_ovf;
    logic [3:0]         r_tx;
    logic [15:0]        r_hdr_predict;
    logic [6:0]         r_hdr_idx;

    logic               w_push_x, w_full, w_drop, w_capture, w_nib_hi, w_blk_end;
    logic               w_ack_low_nxt, w_idx_bad, w_clr;
    logic [CNT_W-1:0]   w_cnt_inc;

    adpcm_toggle_detect u_push_det (
        .i_clk    (i_clk),
        .i_sig    (i_push),
        .o_toggle (w_push_x)
    );

    assign w_clr     = i_rst | ~i_enable;
    assign w_full    = (r_state == S_LO) || (r_state == S_HI);
    assign w_drop    = w_push_x & w_full;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_idx_bad = r_idx_byte > 8'(IDX_MAX);

    always_ff @(posedge i_clk) begin
        if (w_clr) r_state <= S_H0;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_capture     = 1'b0;
        w_nib_hi      = 1'b0;
        w_blk_end     = 1'b0;
        w_ack_low_nxt = r_ack_low;
        case (r_state)
            S_H0: if (w_push_x) begin w_capture = 1'b1; w_state_nxt = S_H1; end
            S_H1: if (w_push_x) begin w_capture = 1'b1; w_state_nxt = S_H2; end
            S_H2: if (w_push_x) begin w_capture = 1'b1; w_state_nxt = S_H3; end
            S_H3: begin
                if (w_push_x) begin
                    w_capture = 1'b1;
`ifdef ADPCM_HDR_CLAMP_EN
                    w_state_nxt = S_DATA;
`else
                    w_state_nxt = w_idx_bad ? S_SKIP : S_DATA;
`endif
                end
            end
            S_DATA: if (w_push_x) begin w_capture = 1'b1; w_state_nxt = S_LO; end
            // The decoder drops ack for one cycle after each req toggle; it
            // is latched in r_ack_low so the return to idle is unambiguous.
            S_LO: begin
                if (!i_ack) begin
                    w_ack_low_nxt = 1'b1;
                end else if (r_ack_low) begin
                    w_ack_low_nxt = 1'b0;
                    w_nib_hi      = 1'b1;
                    w_state_nxt   = S_HI;
                end
            end
            S_HI: begin
                if (!i_ack) begin
                    w_ack_low_nxt = 1'b1;
                end else if (r_ack_low) begin
                    w_ack_low_nxt = 1'b0;
                    w_blk_end     = (r_cnt == CNT_W'(BLOCK_BYTES));
                    w_state_nxt   = w_blk_end ? S_H0 : S_DATA;
                end
            end
            S_SKIP: begin
                if (w_push_x) begin
                    w_capture = 1'b1;
                    if (w_cnt_inc == CNT_W'(BLOCK_BYTES)) begin
                        w_blk_end   = 1'b1;
                        w_state_nxt = S_H0;
                    end
                end
            end
            default: w_state_nxt = S_H0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_clr) begin
            r_cnt         <= '0;
            r_pred_lo     <= '0;
            r_pred_hi     <= '0;
            r_idx_byte    <= '0;
            r_byte_hi     <= '0;
            r_ack_low     <= 1'b0;
            r_req         <= 1'b0;
            r_tx          <= '0;
            r_hdr_valid   <= 1'b0;
            r_hdr_predict <= '0;
            r_hdr_idx     <= '0;
            r_hdr_err     <= 1'b0;
            r_ovf         <= 1'b0;
        end else begin
            r_hdr_valid <= 1'b0;
            r_ack_low   <= w_ack_low_nxt;
            if (w_drop) r_ovf <= 1'b1;
            if (w_blk_end)      r_cnt <= '0;
            else if (w_capture) r_cnt <= w_cnt_inc;
            if (w_capture) begin
                case (r_state)
                    S_H0: r_pred_lo  <= i_rx_byte;
                    S_H1: r_pred_hi  <= i_rx_byte;
                    S_H2: r_idx_byte <= i_rx_byte;
                    S_H3: begin
`ifdef ADPCM_HDR_CLAMP_EN
                        r_hdr_predict <= {r_pred_hi, r_pred_lo};
                        r_hdr_idx     <= w_idx_bad ? 7'(IDX_MAX) : r_idx_byte[6:0];
                        r_hdr_valid   <= 1'b1;
`else
                        if (w_idx_bad) begin
                            r_hdr_err <= 1'b1;
                        end else begin
                            r_hdr_predict <= {r_pred_hi, r_pred_lo};
                            r_hdr_idx     <= r_idx_byte[6:0];
                            r_hdr_valid   <= 1'b1;
                        end
`endif
                    end
                    S_DATA: begin
                        r_byte_hi <= i_rx_byte[7:4];
                        r_tx      <= i_rx_byte[3:0];
                        r_req     <= ~r_req;
                    end
                    default: ;
                endcase
            end
            if (w_nib_hi) begin
                r_tx  <= r_byte_hi;
                r_req <= ~r_req;
            end
        end
    end

    assign o_full        = w_full;
    assign o_req         = r_req;
    assign o_tx_adpcm    = r_tx;
    assign o_hdr_valid   = r_hdr_valid;
    assign o_hdr_predict = r_hdr_predict;
    assign o_hdr_idx     = r_hdr_idx;
    assign o_hdr_err     = r_hdr_err;
    assign o_ovf         = r_ovf;
    assign o_cst         = r_state;

endmodule
